// File: rtl/fft_pkg.sv
// Shared FFT definitions: default transform size, sequencer state encoding
// and the bit-reverse helper used by the stage controllers.
package fft_pkg;

   localparam int FFT_N_LOG2 = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RD_A  = 3'd1;
   localparam logic [2:0] ST_RD_B  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Reverses the low 'width' bits of value (width <= 16); upper bits come back zero.
   function automatic logic [15:0] bit_reverse(input logic [15:0] value, input int width);
      logic [15:0] mirrored;
      mirrored = {<<{value}};
      return mirrored >> (16 - width);
   endfunction

endpackage

// File: rtl/fft_stage0_sequencer_if.sv
// Frame-buffer read port, butterfly issue/result port and working-RAM write
// port of the stage-0 sequencer, bundled as one interface.
interface fft_stage0_sequencer_if
   import fft_pkg::*;
#(
   parameter int N_LOG2 = FFT_N_LOG2,
   parameter int Q_IN   = 15,
   parameter int Q_OUT  = 15
);
   logic                    rd_en;
   logic [N_LOG2-1:0]       rd_addr;
   logic signed [Q_IN:0]    rd_data;

   logic                    bf_valid_in;
   logic signed [Q_IN:0]    bf_a;
   logic signed [Q_IN:0]    bf_b;
   logic                    bf_valid_out;
   logic signed [Q_OUT:0]   bf_y0_real;
   logic signed [Q_OUT:0]   bf_y0_imag;
   logic signed [Q_OUT:0]   bf_y1_real;
   logic signed [Q_OUT:0]   bf_y1_imag;

   logic                    wr_en;
   logic [N_LOG2-1:0]       wr_addr;
   logic signed [Q_OUT:0]   wr_real;
   logic signed [Q_OUT:0]   wr_imag;

   modport master (
      output rd_en, rd_addr,
      input  rd_data,
      output bf_valid_in, bf_a, bf_b,
      input  bf_valid_out, bf_y0_real, bf_y0_imag, bf_y1_real, bf_y1_imag,
      output wr_en, wr_addr, wr_real, wr_imag
   );

   modport slave (
      input  rd_en, rd_addr,
      output rd_data,
      input  bf_valid_in, bf_a, bf_b,
      output bf_valid_out, bf_y0_real, bf_y0_imag, bf_y1_real, bf_y1_imag,
      input  wr_en, wr_addr, wr_real, wr_imag
   );

endinterface

// File: rtl/fft_bitrev_addr_gen.sv
// Pair counter k with bit-reversed pair addresses: a = bitrev(k), b = a + N/2.
module fft_bitrev_addr_gen
   import fft_pkg::*;
#(
   parameter int N_LOG2 = FFT_N_LOG2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              step,
   output logic [N_LOG2-1:0] a_addr,
   output logic [N_LOG2-1:0] b_addr,
   output logic              last
);
   localparam int KW = N_LOG2 - 1;

   logic [KW-1:0] k;
   logic [KW-1:0] k_rev;

   // Pair counter: restarts on clear, advances once per pair.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         k <= '0;
      end else if (step) begin
         k <= k + KW'(1);
      end
   end

   // a lies in the lower half, so b only needs the top address bit set.
   assign k_rev  = KW'(bit_reverse(16'(k), KW));
   assign a_addr = {1'b0, k_rev};
   assign b_addr = {1'b1, k_rev};
   assign last   = (k == '1);

endmodule

// File: rtl/fft_stage0_sequencer.sv
// First radix-2 stage of the real-input FFT: reads sample pairs in
// bit-reversed order, feeds the external butterfly and writes y0/y1 to
// consecutive working-RAM addresses.
module fft_stage0_sequencer
   import fft_pkg::*;
#(
   parameter int N_LOG2 = FFT_N_LOG2,
   parameter int Q_IN   = 15,
   parameter int Q_OUT  = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy,
   output logic done,
   fft_stage0_sequencer_if.master bus
);
   localparam int KW = N_LOG2 - 1;

   logic [2:0]            state;
   logic [2:0]            state_next;
   logic [N_LOG2-1:0]     a_addr;
   logic [N_LOG2-1:0]     b_addr;
   logic                  last_pair;
   logic                  accept;
   logic                  step;
   logic                  issue;
   logic                  wr_y0;
   logic                  wr_y1;
   logic                  check_err;
   logic signed [Q_IN:0]  a_reg;
   logic signed [Q_OUT:0] y1_real_hold;
   logic signed [Q_OUT:0] y1_imag_hold;
   logic [KW-1:0]         wr_pair;

   assign accept = (state == ST_IDLE) && start;
   assign step   = (state == ST_RD_B) && !last_pair;
   assign busy   = (state == ST_RD_A) || (state == ST_RD_B) || (state == ST_DRAIN);
   assign done   = (state == ST_DONE);

   fft_bitrev_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .step   (step),
      .a_addr (a_addr),
      .b_addr (b_addr),
      .last   (last_pair)
   );

   // Next state; DRAIN ends on the final y1 write once nothing is left in flight.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = ST_RD_A;
         ST_RD_A:  state_next = ST_RD_B;
         ST_RD_B:  state_next = last_pair ? ST_DRAIN : ST_RD_A;
         ST_DRAIN: if (wr_y1 && !wr_y0 && !issue) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // State register and the issue -> write-y0 -> write-y1 delay line.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         issue <= 1'b0;
         wr_y0 <= 1'b0;
         wr_y1 <= 1'b0;
      end else begin
         state <= state_next;
         issue <= (state == ST_RD_B);
         wr_y0 <= issue;
         wr_y1 <= wr_y0;
      end
   end

   // Data holding: sample a of the pair, and y1 until its write slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg        <= '0;
         y1_real_hold <= '0;
         y1_imag_hold <= '0;
      end else begin
         if (state == ST_RD_B) a_reg <= bus.rd_data;
         if (wr_y0) begin
            y1_real_hold <= bus.bf_y1_real;
            y1_imag_hold <= bus.bf_y1_imag;
         end
      end
   end

   // Write-pair index and the butterfly valid cross-check.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_pair   <= '0;
         check_err <= 1'b0;
      end else begin
         if (accept) wr_pair <= '0;
         else if (wr_y1) wr_pair <= wr_pair + KW'(1);
         check_err <= busy && (bus.bf_valid_out != wr_y0);
      end
   end

   assert property (@(posedge clk) disable iff (reset) !check_err);

   // Port drive; every data output is forced to zero outside its active slot.
   always_comb begin
      bus.rd_en       = 1'b0;
      bus.rd_addr     = '0;
      bus.bf_valid_in = issue;
      bus.bf_a        = '0;
      bus.bf_b        = '0;
      bus.wr_en       = wr_y0 || wr_y1;
      bus.wr_addr     = '0;
      bus.wr_real     = '0;
      bus.wr_imag     = '0;
      if (state == ST_RD_A) begin
         bus.rd_en   = 1'b1;
         bus.rd_addr = a_addr;
      end else if (state == ST_RD_B) begin
         bus.rd_en   = 1'b1;
         bus.rd_addr = b_addr;
      end
      if (issue) begin
         bus.bf_a = a_reg;
         bus.bf_b = bus.rd_data;
      end
      if (wr_y0) begin
         bus.wr_addr = {wr_pair, 1'b0};
         bus.wr_real = bus.bf_y0_real;
         bus.wr_imag = bus.bf_y0_imag;
      end else if (wr_y1) begin
         bus.wr_addr = {wr_pair, 1'b1};
         bus.wr_real = y1_real_hold;
         bus.wr_imag = y1_imag_hold;
      end
   end

endmodule

// File: doc/fft_stage0_sequencer.md
Name: fft_stage0_sequencer

Overview:
- Sequences the first radix-2 FFT stage of the MFCC frame_fft_block for real-valued input.
- Reads N real samples from the frame buffer in bit-reversed pair order and drives a butterfly_unit_no_imag instance (external, 1-cycle latency).
- Writes the complex results sequentially into the FFT working RAM.
- Starts on a `start` pulse from the frame controller and signals `done` when the stage is complete.

Parameters:
- N_LOG2, 8, log2 of FFT length N; N >= 4.
- Q_IN, 15, sample width minus 1 (samples are Q_IN+1 bits, signed).
- Q_OUT, 15, butterfly result width minus 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run the stage; ignored unless idle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse on completion.
- rd_en  out  1  frame-buffer read strobe; rd_data is valid one cycle later.
- rd_addr  out  N_LOG2  frame-buffer read address.
- rd_data  in  Q_IN+1  frame-buffer read data, signed.
- bf_valid_in  out  1  butterfly issue strobe.
- bf_a  out  Q_IN+1  butterfly input a.
- bf_b  out  Q_IN+1  butterfly input b.
- bf_valid_out  in  1  butterfly result strobe; checked only, never trusted for control.
- bf_y0_real, bf_y0_imag, bf_y1_real, bf_y1_imag  in  Q_OUT+1 each  butterfly results.
- wr_en  out  1  working-RAM write strobe.
- wr_addr  out  N_LOG2  working-RAM write address.
- wr_real, wr_imag  out  Q_OUT+1 each  working-RAM write data.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Reset in any state aborts the operation; no further writes occur.
- Pair addressing, P = N/2 pairs, k = 0..P-1:
  - a_addr = bitrev over (N_LOG2-1) bits of k.
  - b_addr = a_addr + N/2.
  - Outputs go to addresses 2k (y0) and 2k+1 (y1).
- FSM states: IDLE, RD_A, RD_B, DRAIN, DONE.
  - IDLE: start=1 -> RD_A with k=0 and busy=1.
  - RD_A: rd_en=1, rd_addr=a_addr(k) -> RD_B.
  - RD_B: rd_en=1, rd_addr=b_addr(k); latch rd_data as a_reg.
    - If k<P-1: increment k and go to RD_A.
    - Else go to DRAIN.
- Issue stage:
  - In the cycle after each RD_B, bf_valid_in=1, bf_a=a_reg, bf_b=rd_data.
  - This overlaps with the next RD_A.
- Write stage, driven by an internal issue-delay flag (bf_valid_out is not used, since the butterfly's valid_out has no reset):
  - Cycle issue+1: wr_en=1, wr_addr=2k, data = y0; y1 is captured into a holding register.
  - Cycle issue+2: wr_en=1, wr_addr=2k+1, data = held y1.
- Throughput is one pair per 2 cycles, with no write-port conflict.
- Timing, relative to start sampled high in cycle S:
  - First rd_en in S+1.
  - First wr_en in S+4.
  - Last write in S+N+3.
- DRAIN waits for the last write, then enters DONE.
- DONE: done=1 and busy=0 for one cycle (S+N+4) -> IDLE.
- start while busy or in DONE is ignored, not queued.
- Integration check: if bf_valid_out != the internal delayed issue flag while busy, raise an error flag, visible only to simulation assertions.
- Widths: outputs pass through unchanged; no saturation or rounding in this block.

Decomposition:
- Shared package fft_pkg holds the FFT_N_LOG2 default, the FSM state encoding and a bit-reverse function (also used by later stage controllers).
- One natural sub-module, fft_bitrev_addr_gen: k counter plus a/b address generation, reused by the bin-ordering stage.

Test Plan:
- N_LOG2=3, frame x[i]=100*i, start pulse in cycle S:
  - rd_addr sequence is 0,4,2,6,1,5,3,7.
  - Writes are (0:400,0), (1:-400,0), (2:800), (3:-400), (4:600), (5:-400), (6:1000), (7:-400).
  - done pulses at S+12, exactly once.
- Same frame with start re-pulsed at S+3 and S+7: identical write trace, and only one done.
- reset asserted at S+6 for one cycle:
  - From S+7 all outputs are 0 and no writes occur.
  - A new start then produces a clean full run.
- Extremes x[i]=+32767 for i<4 and -32768 for i>=4:
  - Writes follow the Q_OUT wrap of the external butterfly (y0=-1, y1=-1 per pair).
  - The controller passes these values through unchanged.
- Back-to-back runs, start at done+1: the second run begins rd_en at done+2 and produces an identical trace; busy never glitches high during DONE.
- N_LOG2=8 random frame:
  - Scoreboard checks 256 writes against a reference model of the bit-reversed stage 0.
  - done at S+260.
